// File: rtl/delay_tap_ctrl.sv
// ============================================================================
// Module      : delay_tap_ctrl
// Description : Multi-channel delay-line tap controller. Ramps every channel's
//               tap one step at a time toward a requested target, waiting a
//               settle interval after every step. It also decodes each tap
//               into thermometer-style lb/on chain enables.
//               Optional edge-sweep mode is enabled by the macro
//               DELAY_TAP_SWEEP_EN. In that mode the controller walks all
//               chains from tap 0 to the top tap and records, per channel,
//               the first tap at which the sampled chain output differs
//               from the reference sample taken at tap 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_tap_ctrl #(
    parameter int NUM_CH     = 4,
    parameter int TAP_W      = 8,
    parameter int NUM_STAGS  = 256,
    parameter int SETTLE_CYC = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [NUM_CH*TAP_W-1:0]     cfg_tap,
    output logic [NUM_CH*TAP_W-1:0]     cur_tap,
    output logic [NUM_CH*NUM_STAGS-1:0] lb,
    output logic [NUM_CH*NUM_STAGS-1:0] on,
    output logic                        busy,
    output logic                        done,
    input  logic                        sweep_start,
    input  logic [NUM_CH-1:0]           sample_in,
    output logic [NUM_CH-1:0]           edge_found,
    output logic [NUM_CH*TAP_W-1:0]     edge_tap
);

    localparam int            CNT_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

`ifdef DELAY_TAP_SWEEP_EN
    localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(NUM_STAGS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_STEP      = 3'd1,
        S_SETTLE    = 3'd2,
        S_DONE      = 3'd3,
        S_SW_REF    = 3'd4,
        S_SW_STEP   = 3'd5,
        S_SW_SETTLE = 3'd6,
        S_SW_SAMPLE = 3'd7
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STEP   = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;
`endif

    state_t                      state_q;
    logic [NUM_CH*TAP_W-1:0]     cur_tap_q;
    logic [NUM_CH*TAP_W-1:0]     target_q;
    logic [CNT_W-1:0]            settle_cnt_q;
    logic                        done_q;
    logic [NUM_CH*TAP_W-1:0]     ramp_tap_d;
    logic                        all_match;

`ifdef DELAY_TAP_SWEEP_EN
    logic                        sweep_mode_q;
    logic [NUM_CH-1:0]           ref_q;
    logic [NUM_CH-1:0]           edge_found_q;
    logic [NUM_CH*TAP_W-1:0]     edge_tap_q;
    logic [NUM_CH*TAP_W-1:0]     sweep_tap_d;
`endif

    assign all_match = (cur_tap_q == target_q);

    // Next tap per channel: one step toward target (ramp) or one step up, saturating (sweep)
    always_comb begin
        ramp_tap_d = cur_tap_q;
`ifdef DELAY_TAP_SWEEP_EN
        sweep_tap_d = cur_tap_q;
`endif
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (cur_tap_q[ch*TAP_W +: TAP_W] < target_q[ch*TAP_W +: TAP_W]) begin
                ramp_tap_d[ch*TAP_W +: TAP_W] = cur_tap_q[ch*TAP_W +: TAP_W] + 1'b1;
            end else if (cur_tap_q[ch*TAP_W +: TAP_W] > target_q[ch*TAP_W +: TAP_W]) begin
                ramp_tap_d[ch*TAP_W +: TAP_W] = cur_tap_q[ch*TAP_W +: TAP_W] - 1'b1;
            end
`ifdef DELAY_TAP_SWEEP_EN
            if (cur_tap_q[ch*TAP_W +: TAP_W] != TAP_MAX) begin
                sweep_tap_d[ch*TAP_W +: TAP_W] = cur_tap_q[ch*TAP_W +: TAP_W] + 1'b1;
            end
`endif
        end
    end

    // Controller FSM: tap stepping, settle timing, sweep edge capture and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cur_tap_q    <= '0;
            target_q     <= '0;
            settle_cnt_q <= '0;
            done_q       <= 1'b0;
`ifdef DELAY_TAP_SWEEP_EN
            sweep_mode_q <= 1'b0;
            ref_q        <= '0;
            edge_found_q <= '0;
            edge_tap_q   <= '0;
`endif
        end else begin
            // The completion pulse follows the single DONE cycle
            done_q <= (state_q == S_DONE);
            case (state_q)
                S_IDLE: begin
                    // A configuration request takes precedence over a sweep request
                    if (cfg_valid) begin
                        target_q <= cfg_tap;
                        state_q  <= S_STEP;
`ifdef DELAY_TAP_SWEEP_EN
                        sweep_mode_q <= 1'b0;
                    end else if (sweep_start) begin
                        target_q     <= '0;
                        edge_found_q <= '0;
                        edge_tap_q   <= '0;
                        sweep_mode_q <= 1'b1;
                        state_q      <= S_STEP;
`endif
                    end
                end
                S_STEP: begin
                    if (all_match) begin
`ifdef DELAY_TAP_SWEEP_EN
                        state_q <= sweep_mode_q ? S_SW_REF : S_DONE;
`else
                        state_q <= S_DONE;
`endif
                    end else begin
                        cur_tap_q    <= ramp_tap_d;
                        settle_cnt_q <= SETTLE_LOAD;
                        state_q      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt_q == '0) begin
                        state_q <= S_STEP;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
`ifdef DELAY_TAP_SWEEP_EN
                    sweep_mode_q <= 1'b0;
`endif
                end
`ifdef DELAY_TAP_SWEEP_EN
                S_SW_REF: begin
                    ref_q   <= sample_in;
                    state_q <= S_SW_STEP;
                end
                S_SW_STEP: begin
                    cur_tap_q    <= sweep_tap_d;
                    settle_cnt_q <= SETTLE_LOAD;
                    state_q      <= S_SW_SETTLE;
                end
                S_SW_SETTLE: begin
                    if (settle_cnt_q == '0) begin
                        state_q <= S_SW_SAMPLE;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - 1'b1;
                    end
                end
                S_SW_SAMPLE: begin
                    // Only the first transition seen on each channel is recorded
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        if (!edge_found_q[ch] && (sample_in[ch] != ref_q[ch])) begin
                            edge_found_q[ch]               <= 1'b1;
                            edge_tap_q[ch*TAP_W +: TAP_W]  <= cur_tap_q[ch*TAP_W +: TAP_W];
                        end
                    end
                    // All channels move in lockstep during a sweep, so channel 0 marks the end
                    if (cur_tap_q[TAP_W-1:0] == TAP_MAX) begin
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_SW_STEP;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cur_tap   = cur_tap_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);
    assign cfg_ready = (state_q == S_IDLE);

`ifdef DELAY_TAP_SWEEP_EN
    assign edge_found = edge_found_q;
    assign edge_tap   = edge_tap_q;
`else
    logic unused_sweep_inputs;
    assign unused_sweep_inputs = ^{sweep_start, sample_in};
    assign edge_found          = '0;
    assign edge_tap            = '0;
`endif

    // Thermometer decode: stages below the tap are cleared in lb and set in on
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_decode
        assign lb[ch*NUM_STAGS +: NUM_STAGS] = {NUM_STAGS{1'b1}} << cur_tap_q[ch*TAP_W +: TAP_W];
        assign on[ch*NUM_STAGS +: NUM_STAGS] = ~lb[ch*NUM_STAGS +: NUM_STAGS];
    end : g_decode

endmodule

`default_nettype wire
